// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle sequencer for the RV32M multiply/divide ops.
// A registered 33x33 signed multiplier and a 32-iteration restoring divider
// share one FSM. busy stalls the pipeline while an op is in flight, and done
// pulses for one cycle when result holds the architectural value.
module muldiv_seq #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  alu_op,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t state, state_nxt;

    logic [5:0]         cnt;
    logic [1:0]         op_q;     // alu_op[3:2] of the op in flight
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic signed [63:0] prod;
    logic [31:0]        div_q;    // dividend shifts out, quotient shifts in
    logic [31:0]        div_r;
    logic [31:0]        div_d;
    logic               neg_q;
    logic               neg_r;

    // alu_op[1] does not take part in M-op decoding
    logic unused_op_bit;
    assign unused_op_bit = alu_op[1];

    // Request decode, evaluated on the raw inputs at the accept edge
    logic        accept;
    logic        is_div;
    logic        div_signed;
    logic        rem_op;
    logic        div_zero;
    logic        div_ovf;
    logic        div_special;
    logic [31:0] special_res;
    logic [31:0] mag1;
    logic [31:0] mag2;

    assign accept      = start && alu_op[0] && !flush &&
                         (state == S_IDLE || state == S_DONE);
    assign is_div      = alu_op[4];
    assign div_signed  = !alu_op[2];
    assign rem_op      = alu_op[3];
    assign div_zero    = (data2 == 32'h0);
    assign div_ovf     = div_signed && (data1 == 32'h8000_0000) && (data2 == 32'hFFFF_FFFF);
    assign div_special = is_div && (div_zero || div_ovf);
    assign special_res = div_zero ? (rem_op ? data1 : 32'hFFFF_FFFF)
                                  : (rem_op ? 32'h0 : 32'h8000_0000);
    assign mag1        = (div_signed && data1[31]) ? -data1 : data1;
    assign mag2        = (div_signed && data2[31]) ? -data2 : data2;

    // Low 64 bits of the 66-bit signed product are all that is ever returned
    assign prod = 64'(mul_a) * 64'(mul_b);

    // One restoring shift-subtract step
    logic [32:0] step_sh;
    logic        step_take;
    logic [31:0] step_sub;

    assign step_sh   = {div_r, div_q[31]};
    assign step_take = (step_sh >= {1'b0, div_d});
    assign step_sub  = step_sh[31:0] - div_d;

    // Next-state logic; flush overrides everything and returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (!is_div)          state_nxt = S_MUL;
                    else if (div_special) state_nxt = S_DONE;
                    else                  state_nxt = S_DIV;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_MUL:   if (cnt == MUL_LAST) state_nxt = S_DONE;
            S_DIV:   if (cnt == 6'd31)    state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    // State register with registered busy/done decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_MUL) || (state_nxt == S_DIV) || (state_nxt == S_FIX);
            done  <= (state_nxt == S_DONE);
        end
    end

    // Operand latch, multiply/divide iteration and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= 32'h0;
            cnt    <= 6'd0;
            op_q   <= 2'b00;
            mul_a  <= '0;
            mul_b  <= '0;
            div_q  <= 32'h0;
            div_r  <= 32'h0;
            div_d  <= 32'h0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (accept) begin
            op_q  <= alu_op[3:2];
            cnt   <= is_div ? 6'd0 : 6'd1;
            // MULHU zero-extends rs1; MULHU and MULHSU zero-extend rs2
            mul_a <= {(alu_op[3:2] != 2'b10) && data1[31], data1};
            mul_b <= {!alu_op[3] && data2[31], data2};
            div_q <= mag1;
            div_r <= 32'h0;
            div_d <= mag2;
            neg_q <= div_signed && (data1[31] ^ data2[31]);
            neg_r <= div_signed && data1[31];
            if (div_special) result <= special_res;
        end else if (!flush) begin
            case (state)
                S_MUL: begin
                    if (cnt == MUL_LAST) begin
                        result <= (op_q == 2'b00) ? prod[31:0] : prod[63:32];
                        cnt    <= 6'd0;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_DIV: begin
                    div_r <= step_take ? step_sub : step_sh[31:0];
                    div_q <= {div_q[30:0], step_take};
                    cnt   <= (cnt == 6'd31) ? 6'd0 : cnt + 6'd1;
                end
                S_FIX: begin
                    if (op_q[1]) result <= neg_r ? -div_r : div_r;
                    else         result <= neg_q ? -div_q : div_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq with hand-computed expected values.
module tb_muldiv_seq;

    localparam logic [4:0] OP_MUL    = 5'b00001;
    localparam logic [4:0] OP_MULH   = 5'b00101;
    localparam logic [4:0] OP_MULHU  = 5'b01001;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_DIV    = 5'b10001;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b11001;
    localparam logic [4:0] OP_REMU   = 5'b11101;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  alu_op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.MUL_CYCLES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .alu_op (alu_op),
        .data1  (data1),
        .data2  (data2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle, then scramble the operand inputs
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        alu_op = op;
        data1  = a;
        data2  = b;
        @(posedge clk); #1;
        start  = 1'b0;
        alu_op = 5'b10000;
        data1  = 32'hDEAD_BEEF;
        data2  = 32'h0;
    endtask

    // Step cycles until done, counting elapsed cycles and busy cycles
    task automatic wait_done(input int n0, output int n, output int bcnt);
        n    = n0;
        bcnt = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        int bc;
        issue(op, a, b);
        wait_done(1, n, bc);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_res"}, result, exp);
        chk({tag, "_busycyc"}, 32'(bc), 32'(lat - 1));
        chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int n;
        int bc;
        int dcnt;

        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        alu_op = 5'b0;
        data1  = 32'h0;
        data2  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("mul",    OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 3);
        run_op("mulh",   OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 3);
        run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);

        run_op("div_m7_2",  OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        run_op("rem_m7_2",  OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        run_op("div_7_m2",  OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run_op("rem_7_m2",  OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         34);
        run_op("divu_max",  OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34);
        run_op("remu_100_7", OP_REMU, 32'd100,      32'd7,         32'd2,         34);

        run_op("div_by0",  OP_DIV,  32'd1234,      32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu_by0", OP_REMU, 32'd5,         32'd0,         32'd5,         1);
        run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Asynchronous reset in cycle 10 of a divide
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);

        // Flush in cycle c+15 of a divide: no done, result retained
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (14) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        dcnt = 0;
        repeat (40) begin
            if (done === 1'b1) dcnt++;
            @(posedge clk); #1;
        end
        chk("flush_no_done", 32'(dcnt), 32'd0);
        chk("flush_result", result, 32'd14);

        // start together with flush is not accepted
        start  = 1'b1;
        flush  = 1'b1;
        alu_op = OP_MUL;
        data1  = 32'd3;
        data2  = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        dcnt  = 0;
        bc    = 0;
        repeat (6) begin
            if (done === 1'b1) dcnt++;
            if (busy === 1'b1) bc++;
            @(posedge clk); #1;
        end
        chk("stflush_busy", 32'(bc), 32'd0);
        chk("stflush_done", 32'(dcnt), 32'd0);

        // start with alu_op[0]=0 is ignored
        start  = 1'b1;
        alu_op = 5'b10100;
        data1  = 32'd100;
        data2  = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        chk("nonm_busy", {31'b0, busy}, 32'd0);
        chk("nonm_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back: MUL accepted in the DONE cycle of a DIVU
        issue(OP_DIVU, 32'd50, 32'd5);
        wait_done(1, n, bc);
        chk("b2b_div_lat", 32'(n), 32'd34);
        chk("b2b_div_res", result, 32'd10);
        issue(OP_MUL, 32'd6, 32'd7);
        chk("b2b_busy_rise", {31'b0, busy}, 32'd1);
        wait_done(1, n, bc);
        chk("b2b_mul_lat", 32'(n), 32'd3);
        chk("b2b_mul_res", result, 32'd42);
        @(posedge clk); #1;

        // start with a different op during a divide is ignored
        issue(OP_DIVU, 32'd1000, 32'd10);
        repeat (4) @(posedge clk);
        #1;
        start  = 1'b1;
        alu_op = OP_MUL;
        data1  = 32'd3;
        data2  = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(6, n, bc);
        chk("ign_lat", 32'(n), 32'd34);
        chk("ign_res", result, 32'd100);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV32M operations in the EX stage. It accepts one multiply or divide request at a time and runs it on a registered multiplier and a 32-iteration restoring divider. It asserts `busy` so the hazard unit stalls the pipeline, then presents the architecturally correct result with a one-cycle `done` pulse. Non-M operations bypass it and stay in the single-cycle ALU.

## Interface
- `MUL_CYCLES`, default 2: cycles spent in MUL state; legal range 1..4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request valid for one cycle.
- `alu_op`  in  5  op code. M ops: 00001 MUL, 00101 MULH, 01001 MULHU, 01101 MULHSU, 10001 DIV, 10101 DIVU, 11001 REM, 11101 REMU.
- `data1`  in  32  rs1 operand (dividend / multiplicand).
- `data2`  in  32  rs2 operand (divisor / multiplier).
- `flush`  in  1  synchronous abort from a branch mispredict or trap.
- `busy`  out  1  operation in flight; the pipeline must stall.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  32  registered result; holds until the next accepted op completes.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- **Accept:** `start`=1 and `alu_op[0]`=1 in IDLE or DONE, with `flush`=0. Operands and op are latched at that edge.
- **Ignored requests:**
  - `start` while in MUL, DIV or FIX is ignored.
  - `start` with `alu_op[0]`=0 is ignored; no state change.
- **Multiply (op[4]=0):**
  - Operands are extended to 33 bits. MUL, MULH and the MULHSU rs1 side are sign-extended; MULHU and the MULHSU rs2 side are zero-extended.
  - Forms a 66-bit signed product.
  - MUL returns bits [31:0]; MULH, MULHU and MULHSU return bits [63:32].
  - Path: accept → MUL. A cycle counter runs 1..MUL_CYCLES; the product is registered on the last MUL edge → DONE.
- **Divide (op[4]=1):** special cases are resolved at the accept edge and go directly to DONE with `result` loaded.
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `data1`.
  - Signed overflow (DIV/REM, `data1`=0x80000000, `data2`=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- **Divide, normal path:** accept → DIV.
  - DIV operates on magnitudes; signed ops take absolute values. It performs one restoring shift-subtract per edge for 32 edges, with a 6-bit counter 0..31, then → FIX.
  - FIX applies the signs for signed ops: the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign. FIX registers the quotient (DIV/DIVU) or remainder (REM/REMU) into `result`, then → DONE.
- **DONE:** lasts one cycle. Next state is IDLE, or the new op if a request is accepted in this cycle.
- **Flush:** `flush`=1 in any state → IDLE at the next edge.
  - No `done` is produced and `result` is unchanged.
  - `flush` and `start` in the same cycle: `flush` wins and nothing is accepted.
  - A flush in the cycle where `done`=1 does not retract that pulse.
- **Reset:** state IDLE, `busy`=0, `done`=0, `result`=0, counters 0, operand registers 0.

## Timing
- Request in cycle c (sampled at the end of c). Latency L means `done`=1 in cycle c+L.
  - Multiply: L = 1+MUL_CYCLES (default 3).
  - Divide special case: L = 1.
  - Divide normal: L = 34 (DIV in c+1..c+32, FIX in c+33, DONE in c+34).
- `busy`=1 exactly in MUL, DIV and FIX, so it is 0 in the `done` cycle. A special-case divide never raises `busy`.
- Back-to-back: a request in the DONE cycle is accepted, and `busy` rises in the next cycle.
- `done`, `busy` and `result` are all registered; there is no combinational path from inputs to outputs.
- Operand inputs may change after the accept edge without affecting the op in flight.

## Test plan
- **Reset:** assert `rst` mid-divide (cycle 10 of DIV) → next cycle `busy`=0, `done`=0, `result`=0; a subsequent DIVU 100/7 → `result`=14 at c+34.
- **MUL / MULH (MUL_CYCLES=2):**
  - MUL 7 × 0xFFFFFFFD → `result`=0xFFFFFFEB, `done` in c+3, `busy`=1 in c+1..c+2.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed divide:** DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; each has `done` in exactly c+34 and `busy` high for 33 cycles.
- **Special cases:** DIV x/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/−1 → 0x80000000; REM of the same → 0. All at L=1 with `busy` never 1.
- **Flush:** flush in cycle c+15 of a DIV → IDLE, no `done`, `result` keeps its previous value. `start`+`flush` in the same cycle → not accepted.
- **Back-to-back:** MUL accepted in the DONE cycle of a DIVU → second `done` 3 cycles later with the correct product. `start` during DIV with a different op → ignored, and the original result is returned.
